// File: rtl/sbox_layer_sched.sv
// Folded AES byte-substitution engine: LANES S_Sbox cells shared by two requesters, one 128-bit job at a time.
// Optional SBOX_SCHED_PERF_EN adds saturating perf_jobs / perf_stall counters.
module sbox_layer_sched #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
`ifdef SBOX_SCHED_PERF_EN
    ,
    output logic [31:0]  perf_jobs,
    output logic [31:0]  perf_stall
`endif
);

    localparam int unsigned BEATS  = 16 / LANES;
    localparam int unsigned GRP_W  = 8 * LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [127:0]       work, work_next;
    logic [BEAT_W-1:0]  beat, beat_next;
    logic               rsp_id_next;
    logic               last_id, last_id_next;
    logic               any_valid, grant, last_beat;
    logic [GRP_W-1:0]   grp_in, grp_out;

    assign any_valid = req0_valid | req1_valid;
    // Tie goes to the requester that was not served last.
    assign grant     = req1_valid & (~req0_valid | ~last_id);
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign rsp_data  = work;

    // Byte group selected by the current beat; beat 0 is the MSB group.
    always_comb begin
        grp_in = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) grp_in = work[127 - GRP_W*b -: GRP_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        S_Sbox u_sbox (
            .x (grp_in [GRP_W - 1 - 8*l -: 8]),
            .y (grp_out[GRP_W - 1 - 8*l -: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = RUN;
            RUN:     if (last_beat) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        work_next    = work;
        beat_next    = beat;
        rsp_id_next  = rsp_id;
        last_id_next = last_id;
        case (state)
            IDLE: begin
                req0_ready = any_valid & ~grant;
                req1_ready = any_valid & grant;
                if (any_valid) begin
                    work_next   = grant ? req1_data : req0_data;
                    rsp_id_next = grant;
                    beat_next   = '0;
                end
            end
            RUN: begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (beat == BEAT_W'(b)) work_next[127 - GRP_W*b -: GRP_W] = grp_out;
                end
                beat_next = last_beat ? '0 : beat + BEAT_W'(1);
            end
            DONE: begin
                if (rsp_ready) last_id_next = rsp_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            beat      <= '0;
            rsp_id    <= 1'b0;
            last_id   <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            work      <= work_next;
            beat      <= beat_next;
            rsp_id    <= rsp_id_next;
            last_id   <= last_id_next;
            rsp_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

`ifdef SBOX_SCHED_PERF_EN
    // Saturating job and response-stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (perf_jobs != '1))
                perf_jobs <= perf_jobs + 32'd1;
            if ((state == DONE) && !rsp_ready && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// AES S-box byte cell: GF(2^8) inverse (x^254) followed by the affine map.
module S_Sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x3, x7, x15, x31, x63, x127, inv;

    // Square-and-multiply chain; 0 maps to 0 as required.
    always_comb begin
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        inv  = gf_mul(x127, x127);
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: tb/tb_sbox_layer_sched.sv
// Directed bench for sbox_layer_sched at LANES=4: latency, byte placement, arbitration, backpressure, mid-job reset.
module tb_sbox_layer_sched;

    logic         clk, rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_data, req1_data, rsp_data;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
`ifdef SBOX_SCHED_PERF_EN
    logic [31:0]  perf_jobs, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int lat;
    logic e;

    localparam logic [127:0] ALL63    = {16{8'h63}};
    localparam logic [127:0] ROW0_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ROW0_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ROW1_IN  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] ROW1_OUT = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    localparam logic [127:0] PART2    = 128'h637c777bf26b6fc508090a0b0c0d0e0f;

    sbox_layer_sched #(.LANES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef SBOX_SCHED_PERF_EN
        ,
        .perf_jobs  (perf_jobs),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_rsp_data",  rsp_data,        128'(0));
        chk("rst_rsp_id",    128'(rsp_id),    128'(0));
        rst_n = 1'b1;

        // Job A: zero word from req0
        req0_data = '0; req0_valid = 1'b1; #1;
        chk("a_req0_ready", 128'(req0_ready), 128'(1));
        chk("a_req1_ready", 128'(req1_ready), 128'(0));
        chk("a_busy_idle",  128'(busy),       128'(0));
        tick();
        req0_valid = 1'b0;
        chk("a_busy_run",   128'(busy),       128'(1));
        chk("a_valid_run",  128'(rsp_valid),  128'(0));
        wait_rsp(lat);
        chk("a_latency",    128'(lat),        128'(4));
        chk("a_rsp_data",   rsp_data,         ALL63);
        chk("a_rsp_id",     128'(rsp_id),     128'(0));
        tick();
        chk("a_valid_after", 128'(rsp_valid), 128'(0));
        chk("a_busy_after",  128'(busy),      128'(0));

        // Job B: byte placement through req1
        req1_data = ROW0_IN; req1_valid = 1'b1; #1;
        chk("b_req1_ready", 128'(req1_ready), 128'(1));
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("b_latency",    128'(lat),        128'(4));
        chk("b_rsp_data",   rsp_data,         ROW0_OUT);
        chk("b_rsp_id",     128'(rsp_id),     128'(1));
        tick();

        // Both requesters held: grant order 0,1,0
        do_reset();
        req0_data = '0; req1_data = ROW1_IN;
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        for (int j = 0; j < 3; j++) begin
            e = (j == 1);
            chk("arb_req0_ready", 128'(req0_ready), 128'(!e));
            chk("arb_req1_ready", 128'(req1_ready), 128'(e));
            tick();
            chk("arb_run_ready0", 128'(req0_ready), 128'(0));
            chk("arb_run_ready1", 128'(req1_ready), 128'(0));
            wait_rsp(lat);
            chk("arb_latency",    128'(lat),        128'(4));
            chk("arb_rsp_id",     128'(rsp_id),     128'(e));
            chk("arb_rsp_data",   rsp_data,         e ? ROW1_OUT : ALL63);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: ten stalled DONE edges
        do_reset();
        rsp_ready = 1'b0;
        req0_data = ROW0_IN; req1_data = ROW1_IN;
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("bp_req0_ready", 128'(req0_ready), 128'(1));
        tick();
        req0_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_data",   rsp_data,         ROW0_OUT);
            chk("bp_rsp_id",     128'(rsp_id),     128'(0));
            chk("bp_req0_ready", 128'(req0_ready), 128'(0));
            chk("bp_req1_ready", 128'(req1_ready), 128'(0));
            chk("bp_busy",       128'(busy),       128'(1));
            tick();
        end
        chk("bp_still_valid", 128'(rsp_valid), 128'(1));
`ifdef SBOX_SCHED_PERF_EN
        chk("bp_perf_stall", 128'(perf_stall), 128'(10));
        chk("bp_perf_jobs0", 128'(perf_jobs),  128'(0));
`endif
        rsp_ready = 1'b1; req1_valid = 1'b0;
        tick();
        chk("bp_released", 128'(rsp_valid), 128'(0));
`ifdef SBOX_SCHED_PERF_EN
        chk("bp_perf_jobs1",  128'(perf_jobs),  128'(1));
        chk("bp_perf_stall2", 128'(perf_stall), 128'(10));
`endif

        // Reset at beat 2 discards the job
        req0_data = ROW0_IN; req0_valid = 1'b1; #1;
        chk("mr_req0_ready", 128'(req0_ready), 128'(1));
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        chk("mr_partial", rsp_data, PART2);
        rst_n = 1'b0; #1;
        chk("mr_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("mr_rsp_data",  rsp_data,        128'(0));
        chk("mr_busy",      128'(busy),      128'(0));
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("mr_no_rsp",    128'(rsp_valid), 128'(0));
        req0_data = '0; req1_data = ROW1_IN;
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("mr_tie_req0",  128'(req0_ready), 128'(1));
        chk("mr_tie_req1",  128'(req1_ready), 128'(0));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat);
        chk("mr_latency",   128'(lat),       128'(4));
        chk("mr_rsp_data",  rsp_data,        ALL63);
        chk("mr_rsp_id",    128'(rsp_id),    128'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
